// File: rtl/uart_bit_rx_module.sv
// UART receive bit engine: deserialises 8N1 frames from rx_pin and presents
// each byte on a valid/ready handshake, flagging framing errors and overruns.
module uart_bit_rx_module #(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 3;

  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REC_BYTE,
    S_STOP,
    S_DATA
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_d;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cycle_cnt_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shift;
  logic             fall_c;
  logic             sample_c;
  logic             bit_end_c;
  logic             capture_c;
  logic             load_c;
  logic             frame_err_c;

  // Two-flop synchroniser plus one delay flop for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_pin;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall_c = rx_d & ~rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_next  = state;
    sample_c    = (cycle_cnt == CNT_SAMPLE);
    bit_end_c   = (cycle_cnt == CNT_END);
    capture_c   = 1'b0;
    load_c      = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall_c) state_next = S_START;
      end
      S_START: begin
        if (sample_c && rx_s2) state_next = S_IDLE;
        else if (bit_end_c)    state_next = S_REC_BYTE;
      end
      S_REC_BYTE: begin
        capture_c = sample_c;
        if (bit_end_c && (bit_cnt == BIT_LAST)) state_next = S_STOP;
      end
      S_STOP: begin
        // Leave at mid stop bit so the following start edge is not missed.
        if (sample_c) begin
          if (rx_s2) begin
            state_next = S_DATA;
          end else begin
            frame_err_c = 1'b1;
            state_next  = S_IDLE;
          end
        end
      end
      S_DATA: begin
        load_c     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state)                   cycle_cnt_next = '0;
    else if ((state == S_REC_BYTE) && bit_end_c) cycle_cnt_next = '0;
    else                                       cycle_cnt_next = cycle_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt_next;
      if (capture_c) shift[bit_cnt] <= rx_s2;
      if (state != S_REC_BYTE) bit_cnt <= '0;
      else if (bit_end_c)      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Byte holding register; newest byte wins when the consumer is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_frame_err <= frame_err_c;
      rx_overrun   <= load_c & rx_data_valid & ~rx_data_ready;
      rx_busy      <= (state_next != S_IDLE);
      if (load_c) begin
        rx_data       <= shift;
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bit_rx_module.sv
// Bench for uart_bit_rx_module: a serial TX model drives frames at nominal and
// skewed baud; received bytes are checked against a queue of expected bytes.
module tb_uart_bit_rx_module;

  localparam int NOM      = 434;
  localparam int HALF_REF = 217;

  logic       clk;
  logic       rst_n;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  uart_bit_rx_module dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_pin       (rx_pin),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       stop;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int valid_rises = 0;
  int valid_cycles = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic valid_q = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Event counters and scoreboard pop on each accepted byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_q = 1'b0;
    end else begin
      if (rx_data_valid && !valid_q) valid_rises++;
      valid_q = rx_data_valid;
      if (rx_data_valid) valid_cycles++;
      if (rx_frame_err) err_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_data_valid && rx_data_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", int'(rx_data), -1);
        end else begin
          check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic bit_hold(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_hold(1'b1, n);
  endtask

  // Serial transmitter model with configurable bit period.
  task automatic tx_frame(input logic [7:0] d, input int period, input logic stop);
    logic [7:0] b;
    b = d;
    bit_hold(1'b0, period);
    for (int i = 0; i < 8; i++) bit_hold(b[i], period);
    bit_hold(stop, period);
  endtask

  task automatic check_quiet_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"},  int'(rx_data), 0);
    check({tag, "_valid"}, int'(rx_data_valid), 0);
    check({tag, "_err"},   int'(rx_frame_err), 0);
    check({tag, "_ovr"},   int'(rx_overrun), 0);
    check({tag, "_busy"},  int'(rx_busy), 0);
  endtask

  initial begin
    int r0, e0, c0, o0, busy_n;

    vecs[0] = '{8'hA5, NOM,       1'b1, 1, 0};
    vecs[1] = '{8'h00, NOM*102/100, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, NOM*102/100, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, NOM*102/100, 1'b1, 1, 0};
    vecs[4] = '{8'h00, NOM*98/100,  1'b1, 1, 0};
    vecs[5] = '{8'hFF, NOM*98/100,  1'b1, 1, 0};
    vecs[6] = '{8'h5A, NOM*98/100,  1'b1, 1, 0};
    vecs[7] = '{8'h3C, NOM,       1'b0, 0, 1};
    vecs[8] = '{8'h55, NOM,       1'b1, 1, 0};

    rst_n = 1'b0;
    rx_pin = 1'b1;
    rx_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    check_quiet_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(20);

    // Table: nominal, +/-2% baud, framing error followed by a good frame.
    rx_data_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      r0 = valid_rises; e0 = err_cnt; c0 = valid_cycles; o0 = ovr_cnt;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      tx_frame(vecs[i].data, vecs[i].period, vecs[i].stop);
      idle(50);
      check($sformatf("v%0d_valid", i), valid_rises - r0, vecs[i].exp_valid);
      check($sformatf("v%0d_vcyc", i), valid_cycles - c0, vecs[i].exp_valid);
      check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d_ovr", i), ovr_cnt - o0, 0);
      check($sformatf("v%0d_busy", i), int'(rx_busy), 0);
    end

    // Start-bit glitch of 100 clocks.
    r0 = valid_rises; e0 = err_cnt; busy_n = 0;
    rx_pin = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      #1;
      if (k == 100) rx_pin = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_n++;
    end
    check("glitch_busy_seen", int'(busy_n > 0), 1);
    check("glitch_busy_len", int'(busy_n <= HALF_REF + 3), 1);
    check("glitch_valid", valid_rises - r0, 0);
    check("glitch_err", err_cnt - e0, 0);
    @(posedge clk);
    #1;

    // Back-to-back bytes with consumer stalled: newest wins, one overrun.
    rx_data_ready = 1'b0;
    r0 = valid_rises; o0 = ovr_cnt;
    exp_q.push_back(8'hFF);
    tx_frame(8'h00, NOM, 1'b1);
    tx_frame(8'hFF, NOM, 1'b1);
    idle(50);
    @(negedge clk);
    check("ovr_valid_held", int'(rx_data_valid), 1);
    check("ovr_data", int'(rx_data), 8'hFF);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_rises", valid_rises - r0, 1);
    @(posedge clk);
    #1;
    rx_data_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
    @(negedge clk);
    check("ovr_accepted", int'(rx_data_valid), 0);
    check("ovr_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset during bit 3 of 0x12, then a clean 0x81.
    rx_data_ready = 1'b1;
    r0 = valid_rises;
    bit_hold(1'b0, NOM);
    bit_hold(1'b0, NOM);
    bit_hold(1'b1, NOM);
    bit_hold(1'b0, NOM);
    bit_hold(1'b0, 200);
    rst_n = 1'b0;
    rx_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(50);
    check("midrst_novalid", valid_rises - r0, 0);
    check("midrst_busy", int'(rx_busy), 0);
    r0 = valid_rises; e0 = err_cnt;
    exp_q.push_back(8'h81);
    tx_frame(8'h81, NOM, 1'b1);
    idle(50);
    check("after_rst_valid", valid_rises - r0, 1);
    check("after_rst_err", err_cnt - e0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
